per_out_fifo: RTL and testbench
===============================

// Module: per_out_fifo
// PURPOSE
//  - openMSP430 peripheral-bus slave that captures the CPU's program output stream.
//  - Each 16-bit word written to DATA (byte 0x0100) is pushed into a FIFO.
//  - A word value of 0 is not pushed; it sets the end-of-stream flag instead.
//  - FIFO drains over a valid/ready port to a host/trace consumer. Sits on per_* next to the memory models.
// PARAMETERS
//  BASE_ADDR  15'h0100  byte base address; DATA=BASE+0, STAT=BASE+2, CNT=BASE+4
//  DEPTH      16        FIFO entries, power of 2, 2..128
//  AW         4         log2(DEPTH)
// PORTS
//  mclk       in   1   main system clock
//  puc_rst    in   1   reset, asynchronous, active-high
//  per_addr   in   14  peripheral word address (byte addr >> 1)
//  per_din    in   16  peripheral write data
//  per_en     in   1   peripheral access enable
//  per_we     in   2   byte write enables, high active
//  per_dout   out  16  read data; 0 when not selected
//  out_data   out  16  FIFO head word
//  out_valid  out  1   head valid (FIFO not empty)
//  out_ready  in   1   consumer accepts head this cycle
//  out_eof    out  1   end-of-stream flag set AND FIFO empty
//  irq_out    out  1   interrupt (OUT_FIFO_IRQ_EN only, else tied 0)
// BEHAVIOUR
//  - Reset: all pointers 0, count 0, eof=0, ovf=0, hi-water thr=DEPTH/2.
//    Outputs: per_dout=0, out_valid=0, out_data=0, out_eof=0, irq_out=0.
//  - Select: per_en && per_addr[13:2]==BASE_ADDR[14:3]; reg index = per_addr[1:0].
//  - Read (per_we==0): per_dout is combinational in the same cycle.
//    DATA  -> head word, no pop.
//    STAT  -> {count[7:0],4'b0,ovf,eof,full,empty}.
//    CNT   -> {8'b0,thr}.
//    idx3  -> 0.
//  - Write DATA: only per_we==2'b11 acts; partial writes are ignored.
//    Value !=0, not full -> push; write ptr advances next mclk edge.
//    Value !=0, full     -> dropped, ovf<=1. Full is sampled BEFORE a same-cycle pop,
//                           so push on full with simultaneous pop is still dropped.
//    Value ==0           -> eof<=1, nothing pushed; later nonzero pushes still accepted.
//  - Write STAT (any per_we!=0): per_din[3]=1 clears ovf; per_din[2]=1 clears eof. W1C.
//  - Write CNT: per_we[0] loads thr=per_din[7:0]; thr=0 is treated as 1.
//  - Drain: pop when out_valid && out_ready.
//    out_data = mem[rd_ptr], registered-read-free (combinational from the array).
//    Zero-latency: a word pushed at edge N is visible on out_valid after edge N.
//  - Push+pop same cycle, FIFO not full and not empty -> count unchanged, both ptrs advance.
//  - Pointers are AW+1 bits, wrap naturally.
//    full  = (wr[AW]!=rd[AW]) && (wr[AW-1:0]==rd[AW-1:0]).
//    empty = (wr==rd).
//  - out_eof = eof && empty; combinational.
//  - Reset mid-stream: FIFO contents discarded (pointers zeroed); array contents not cleared.
// CONFIGURATION
//  OUT_FIFO_IRQ_EN defined:
//    - irq_out registered, = (count>=thr) | (eof&&empty) | ovf.
//    - Level output; drops the cycle after the cause clears.
//  OUT_FIFO_IRQ_EN undefined:
//    - irq_out is constant 0; no thr compare logic.
//    - CNT reads 0; CNT writes are ignored.
// STRUCTURE
//  - Shared defines file per_out_fifo_defines.v holds:
//    register index constants DATA=0, STAT=1, CNT=2.
//    STAT bit positions EMPTY=0, FULL=1, EOF=2, OVF=3, CNT_LSB=8.
//  - Sub-module per_out_fifo_ram: DEPTHx16 array, one sync write port, one async read port.
//  - Top holds pointers, flags, bus decode, irq.
// TESTING
//  - Push 0x0011,0x0022,0x0033 to 0x0100, out_ready=1 -> out_data 0x0011,0x0022,0x0033
//    on consecutive cycles; out_valid then 0.
//  - 17 writes (DEPTH=16), out_ready=0 -> STAT=0x1002 (count16, full), then ovf=1;
//    write STAT 0x0008 -> ovf=0.
//  - Write 0x0000 with 2 words queued -> out_eof=0 until both popped, then 1;
//    write STAT 0x0004 -> out_eof=0.
//  - Full FIFO, push 0x00AA with out_ready=1 same cycle -> head popped, 0x00AA dropped,
//    ovf=1, count=15.
//  - Byte write per_we=2'b01 to DATA -> no push, STAT unchanged;
//    wrap test: 40 push/pop pairs -> data in order, no ovf.
//  - IRQ_EN: CNT=4, push 4 words -> irq_out=1 next cycle;
//    pop 1 -> irq_out=0; assert puc_rst mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/per_out_fifo_pkg.sv
// ============================================================================
// Module  : per_out_fifo_pkg
// Brief   : Register map and STAT bit layout shared by the output-FIFO slave.
// Revision: 1.0
// ============================================================================
`default_nettype none

package per_out_fifo_pkg;

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_STAT = 2'd1,
        REG_CNT  = 2'd2,
        REG_RSVD = 2'd3
    } reg_idx_e;

    localparam int c_stat_empty   = 0;
    localparam int c_stat_full    = 1;
    localparam int c_stat_eof     = 2;
    localparam int c_stat_ovf     = 3;
    localparam int c_stat_cnt_lsb = 8;

    // A threshold of zero would hold the interrupt permanently; treat it as one.
    function automatic logic [7:0] f_thr_sanitize(input logic [7:0] i_val);
        return (i_val == 8'd0) ? 8'd1 : i_val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/per_out_fifo_ram.sv
// ============================================================================
// Module  : per_out_fifo_ram
// Brief   : DEPTH x 16 storage, one synchronous write port, one async read port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module per_out_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [15:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [15:0]   o_rdata
);

    logic [15:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/per_out_fifo.sv
// ============================================================================
// Module  : per_out_fifo
// Brief   : openMSP430 peripheral slave capturing the program output stream
//           into a FIFO drained over valid/ready. OUT_FIFO_IRQ_EN adds the
//           threshold register and the level interrupt.
// Revision: 1.0
// ============================================================================
`default_nettype none

module per_out_fifo
    import per_out_fifo_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR = 15'h0100,
    parameter int          DEPTH     = 16,
    parameter int          AW        = 4
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_eof,
    output logic        irq_out
);

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          r_eof;
    logic          r_ovf;
    logic [AW:0]   w_count;
    logic [7:0]    w_count8;
    logic          w_empty;
    logic          w_full;
    logic          w_sel;
    reg_idx_e      w_idx;
    logic          w_rd;
    logic          w_data_wr;
    logic          w_stat_wr;
    logic          w_push;
    logic          w_pop;
    logic [15:0]   w_ram_rdata;
    logic [15:0]   w_head;
    logic [15:0]   w_cnt_rd;

    assign w_sel     = per_en && (per_addr[13:2] == BASE_ADDR[14:3]);
    assign w_idx     = reg_idx_e'(per_addr[1:0]);
    assign w_rd      = w_sel && (per_we == 2'b00);
    assign w_data_wr = w_sel && (w_idx == REG_DATA) && (per_we == 2'b11);
    assign w_stat_wr = w_sel && (w_idx == REG_STAT) && (per_we != 2'b00);

    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_count8 = 8'(w_count);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Full is judged before any same-cycle pop, so a push into a full FIFO drops.
    assign w_push = w_data_wr && (per_din != 16'd0) && !w_full;
    assign w_pop  = !w_empty && out_ready;

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_eof    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_data_wr && (per_din == 16'd0)) begin
                r_eof <= 1'b1;
            end else if (w_stat_wr && per_din[c_stat_eof]) begin
                r_eof <= 1'b0;
            end
            if (w_data_wr && (per_din != 16'd0) && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_stat_wr && per_din[c_stat_ovf]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    per_out_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (mclk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (per_din),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_ram_rdata)
    );

    assign w_head    = w_empty ? 16'd0 : w_ram_rdata;
    assign out_data  = w_head;
    assign out_valid = !w_empty;
    assign out_eof   = r_eof && w_empty;

`ifdef OUT_FIFO_IRQ_EN
    logic [7:0] r_thr;
    logic       r_irq;

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_thr <= 8'(DEPTH / 2);
            r_irq <= 1'b0;
        end else begin
            if (w_sel && (w_idx == REG_CNT) && per_we[0]) begin
                r_thr <= f_thr_sanitize(per_din[7:0]);
            end
            r_irq <= (w_count8 >= r_thr) || (r_eof && w_empty) || r_ovf;
        end
    end

    assign w_cnt_rd = {8'd0, r_thr};
    assign irq_out  = r_irq;
`else
    assign w_cnt_rd = 16'd0;
    assign irq_out  = 1'b0;
`endif

    always_comb begin
        per_dout = 16'd0;
        if (w_rd) begin
            case (w_idx)
                REG_DATA: per_dout = w_head;
                REG_STAT: per_dout = {w_count8, 4'b0000, r_ovf, r_eof, w_full, w_empty};
                REG_CNT:  per_dout = w_cnt_rd;
                default:  per_dout = 16'd0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_per_out_fifo.sv
// ============================================================================
// Module  : tb_per_out_fifo
// Brief   : Scoreboard bench for per_out_fifo with a queue-based reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_per_out_fifo;

    localparam int DEPTH = 16;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_eof;
    logic        irq_out;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] sb[$];
    logic        m_eof;
    logic        m_ovf;
    int          m_thr;
    logic        ready_q;
    logic [15:0] mon_exp;

    per_out_fifo dut (
        .mclk      (mclk),
        .puc_rst   (puc_rst),
        .per_addr  (per_addr),
        .per_din   (per_din),
        .per_en    (per_en),
        .per_we    (per_we),
        .per_dout  (per_dout),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_eof   (out_eof),
        .irq_out   (irq_out)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge and hold for one cycle.
    task automatic drive(input logic en, input logic [1:0] idx, input logic [1:0] we,
                         input logic [15:0] din);
        @(posedge mclk);
        #1;
        per_en    = en;
        per_addr  = {12'h020, idx};
        per_we    = we;
        per_din   = din;
        out_ready = ready_q;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 2'b00, 16'd0);
    endtask

    // Model is updated at drive time, when sb still holds the pre-pop contents.
    task automatic wr(input logic [1:0] idx, input logic [15:0] din, input logic [1:0] we);
        drive(1'b1, idx, we, din);
        if (idx == 2'd0 && we == 2'b11) begin
            if (din == 16'd0)
                m_eof = 1'b1;
            else if (sb.size() == DEPTH)
                m_ovf = 1'b1;
            else
                sb.push_back(din);
        end else if (idx == 2'd1 && we != 2'b00) begin
            if (din[3]) m_ovf = 1'b0;
            if (din[2]) m_eof = 1'b0;
        end
`ifdef OUT_FIFO_IRQ_EN
        else if (idx == 2'd2 && we[0]) begin
            m_thr = (din[7:0] == 8'd0) ? 1 : int'(din[7:0]);
        end
`endif
    endtask

    task automatic rd_check(input logic [1:0] idx, input string name);
        logic [15:0] exp;
        int          cnt;
        drive(1'b1, idx, 2'b00, 16'($urandom));
        cnt = sb.size();
        case (idx)
            2'd0:    exp = (cnt != 0) ? sb[0] : 16'd0;
            2'd1:    exp = {8'(cnt), 4'b0000, m_ovf, m_eof, cnt == DEPTH, cnt == 0};
`ifdef OUT_FIFO_IRQ_EN
            2'd2:    exp = 16'(m_thr);
`endif
            default: exp = 16'd0;
        endcase
        #3;
        check(name, per_dout, exp);
        check({name, "_valid"}, {15'd0, out_valid}, {15'd0, cnt != 0});
        check({name, "_head"}, out_data, (cnt != 0) ? sb[0] : 16'd0);
        check({name, "_eof"}, {15'd0, out_eof}, {15'd0, m_eof && cnt == 0});
`ifndef OUT_FIFO_IRQ_EN
        check({name, "_irq"}, {15'd0, irq_out}, 16'd0);
`endif
    endtask

    task automatic drain();
        ready_q = 1'b1;
        repeat (DEPTH + 2) idle();
        ready_q = 1'b0;
    endtask

    // Monitor: every accepted head word must be the oldest expected word.
    always @(negedge mclk) begin
        if (!puc_rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pop_unexpected: got %h expected no word at %0t", out_data, $time);
            end else begin
                mon_exp = sb.pop_front();
                check("pop_data", out_data, mon_exp);
            end
        end
    end

    initial begin
        puc_rst   = 1'b1;
        per_en    = 1'b0;
        per_addr  = '0;
        per_din   = '0;
        per_we    = '0;
        out_ready = 1'b0;
        ready_q   = 1'b0;
        m_eof     = 1'b0;
        m_ovf     = 1'b0;
        m_thr     = DEPTH / 2;
        repeat (2) @(posedge mclk);
        #1;
        check("rst_valid", {15'd0, out_valid}, 16'd0);
        check("rst_data", out_data, 16'd0);
        check("rst_eof", {15'd0, out_eof}, 16'd0);
        check("rst_irq", {15'd0, irq_out}, 16'd0);
        puc_rst = 1'b0;
        rd_check(2'd1, "rst_stat");
        rd_check(2'd2, "rst_cnt");

        // Streaming three words back to back
        ready_q = 1'b1;
        wr(2'd0, 16'h0011, 2'b11);
        wr(2'd0, 16'h0022, 2'b11);
        wr(2'd0, 16'h0033, 2'b11);
        repeat (3) idle();
        rd_check(2'd0, "stream_done");

        // Fill to full, overflow, clear overflow
        ready_q = 1'b0;
        for (int i = 0; i < DEPTH; i++) wr(2'd0, 16'(i + 1), 2'b11);
        rd_check(2'd1, "full_stat");
        wr(2'd0, 16'h0BAD, 2'b11);
        rd_check(2'd1, "ovf_stat");
        wr(2'd1, 16'h0008, 2'b11);
        rd_check(2'd1, "ovf_clear");

        // Push into full FIFO while popping: push dropped
        ready_q = 1'b1;
        wr(2'd0, 16'h00AA, 2'b11);
        ready_q = 1'b0;
        rd_check(2'd1, "full_pushpop");
        drain();
        wr(2'd1, 16'h000C, 2'b11);

        // End-of-stream marker behind queued words
        wr(2'd0, 16'h0005, 2'b11);
        wr(2'd0, 16'h0006, 2'b11);
        wr(2'd0, 16'h0000, 2'b11);
        rd_check(2'd1, "eof_pending");
        ready_q = 1'b1;
        repeat (2) idle();
        ready_q = 1'b0;
        rd_check(2'd1, "eof_set");
        wr(2'd1, 16'h0004, 2'b01);
        rd_check(2'd1, "eof_clear");

        // Partial writes to DATA are ignored
        wr(2'd0, 16'h1234, 2'b01);
        wr(2'd0, 16'h5678, 2'b10);
        rd_check(2'd1, "partial_wr");

        // Pointer wrap with continuous push/pop
        ready_q = 1'b1;
        for (int i = 0; i < 40; i++) wr(2'd0, 16'($urandom_range(1, 16'hFFFF)), 2'b11);
        idle();
        ready_q = 1'b0;
        rd_check(2'd1, "wrap_stat");

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            int op;
            ready_q = 1'($urandom);
            op = int'($urandom_range(0, 11));
            case (op)
                0, 1, 2, 3, 4: wr(2'd0, ($urandom_range(0, 20) == 0) ? 16'd0 : 16'($urandom_range(1, 16'hFFFF)), 2'b11);
                5:       wr(2'd0, 16'($urandom), 2'($urandom_range(1, 2)));
                6:       rd_check(2'd1, "rnd_stat");
                7:       rd_check(2'd0, "rnd_data");
                8:       wr(2'd1, 16'($urandom), 2'($urandom_range(1, 3)));
                9:       rd_check(2'($urandom_range(2, 3)), "rnd_cnt");
                default: idle();
            endcase
        end
        drain();
        wr(2'd1, 16'h000C, 2'b11);
        rd_check(2'd1, "rnd_end");

`ifdef OUT_FIFO_IRQ_EN
        // Threshold interrupt
        wr(2'd2, 16'h0004, 2'b01);
        for (int i = 0; i < 4; i++) wr(2'd0, 16'(16'h0100 + i), 2'b11);
        idle();
        idle();
        check("irq_set", {15'd0, irq_out}, 16'd1);
        ready_q = 1'b1;
        idle();
        ready_q = 1'b0;
        idle();
        idle();
        check("irq_clear", {15'd0, irq_out}, 16'd0);
`endif

        // Asynchronous reset in the middle of a stream
        ready_q = 1'b0;
        wr(2'd0, 16'h0A0A, 2'b11);
        wr(2'd0, 16'h0B0B, 2'b11);
        idle();
        #2;
        puc_rst = 1'b1;
        #1;
        check("arst_valid", {15'd0, out_valid}, 16'd0);
        check("arst_data", out_data, 16'd0);
        check("arst_eof", {15'd0, out_eof}, 16'd0);
        check("arst_irq", {15'd0, irq_out}, 16'd0);
        sb.delete();
        m_eof = 1'b0;
        m_ovf = 1'b0;
        m_thr = DEPTH / 2;
        @(posedge mclk);
        #1;
        puc_rst = 1'b0;
        rd_check(2'd1, "arst_stat");
        wr(2'd0, 16'h0C0C, 2'b11);
        rd_check(2'd0, "arst_push");
        drain();

        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL final_drain: got %0d words left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
